// File: rtl/fft_pkg.sv
// Shared defaults, state encoding and complex sample layout for the FFT sequencer.
package fft_pkg;

    localparam int FFT_N_LOG2 = 9;
    localparam int FFT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_state_t;

    // RAM word layout: real part in the upper half, imaginary in the lower half.
    typedef struct packed {
        logic signed [FFT_WIDTH-1:0] re;
        logic signed [FFT_WIDTH-1:0] im;
    } cplx_t;

endpackage

// File: rtl/butterfly_mod.sv
// Radix-2 DIT butterfly: x1 = a + b*w, x2 = a - b*w, Q1.15 with wrap-around.
// Define FFT_CTRL_SCALE_EN to floor-halve each output component.
module butterfly_mod
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_a,
    input  logic [2*WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0]   i_w_re,
    input  logic [WIDTH-1:0]   i_w_im,
    output logic [2*WIDTH-1:0] o_x1,
    output logic [2*WIDTH-1:0] o_x2
);

    function automatic logic signed [2*WIDTH:0] f_mul(input logic signed [WIDTH-1:0] x,
                                                      input logic signed [WIDTH-1:0] y);
        return (2*WIDTH+1)'(x) * (2*WIDTH+1)'(y);
    endfunction

    function automatic logic [WIDTH-1:0] f_fit(input logic signed [WIDTH+1:0] v);
`ifdef FFT_CTRL_SCALE_EN
        return WIDTH'(v >>> 1);
`else
        return WIDTH'(v);
`endif
    endfunction

    logic signed [WIDTH-1:0]   w_a_re, w_a_im, w_b_re, w_b_im, w_w_re, w_w_im;
    logic signed [2*WIDTH:0]   w_p_rr, w_p_ii, w_p_ri, w_p_ir;
    logic signed [WIDTH:0]     w_bw_re, w_bw_im;
    logic [WIDTH+1:0]          w_a_re_x, w_a_im_x, w_bw_re_x, w_bw_im_x;

    always_comb begin
        w_a_re  = i_a[2*WIDTH-1:WIDTH];
        w_a_im  = i_a[WIDTH-1:0];
        w_b_re  = i_b[2*WIDTH-1:WIDTH];
        w_b_im  = i_b[WIDTH-1:0];
        w_w_re  = i_w_re;
        w_w_im  = i_w_im;
        w_p_rr  = f_mul(w_b_re, w_w_re);
        w_p_ii  = f_mul(w_b_im, w_w_im);
        w_p_ri  = f_mul(w_b_re, w_w_im);
        w_p_ir  = f_mul(w_b_im, w_w_re);
        // Product back to Q1.15 by truncation; one extra bit keeps the -1 * -1 corner.
        w_bw_re = (WIDTH+1)'((w_p_rr - w_p_ii) >>> (WIDTH-1));
        w_bw_im = (WIDTH+1)'((w_p_ri + w_p_ir) >>> (WIDTH-1));
        w_a_re_x  = {{2{w_a_re[WIDTH-1]}}, w_a_re};
        w_a_im_x  = {{2{w_a_im[WIDTH-1]}}, w_a_im};
        w_bw_re_x = {w_bw_re[WIDTH], w_bw_re};
        w_bw_im_x = {w_bw_im[WIDTH], w_bw_im};
        o_x1 = {f_fit(w_a_re_x + w_bw_re_x), f_fit(w_a_im_x + w_bw_im_x)};
        o_x2 = {f_fit(w_a_re_x - w_bw_re_x), f_fit(w_a_im_x - w_bw_im_x)};
    end

endmodule

// File: rtl/fft_addr_gen.sv
// Maps (stage s, butterfly k) to the in-place DIT operand addresses and twiddle index.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int SW     = 4
) (
    input  logic [SW-1:0]     i_s,
    input  logic [N_LOG2-2:0] i_k,
    output logic [N_LOG2-1:0] o_addr_a,
    output logic [N_LOG2-1:0] o_addr_b,
    output logic [N_LOG2-2:0] o_tw_addr
);

    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
    localparam logic [N_LOG2-1:0] ONE    = N_LOG2'(1);

    logic [N_LOG2-2:0] w_mask;
    logic [N_LOG2-2:0] w_j;
    logic [N_LOG2-2:0] w_g;

    always_comb begin
        w_mask    = ~({(N_LOG2-1){1'b1}} << i_s);
        w_j       = i_k & w_mask;
        w_g       = i_k >> i_s;
        o_addr_a  = ({1'b0, w_g} << i_s << 1'b1) + {1'b0, w_j};
        // Bit s of addr_a is always clear, so the partner sits exactly half above it.
        o_addr_b  = o_addr_a + (ONE << i_s);
        o_tw_addr = w_j << (S_LAST - i_s);
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one butterfly issued per cycle over all stages.
// Define FFT_CTRL_SCALE_EN to halve every butterfly output (total gain 1/N).
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int WIDTH  = FFT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [N_LOG2-1:0]     rd_addr_a,
    output logic [N_LOG2-1:0]     rd_addr_b,
    input  logic [2*WIDTH-1:0]    rd_data_a,
    input  logic [2*WIDTH-1:0]    rd_data_b,
    output logic [N_LOG2-2:0]     tw_addr,
    input  logic [WIDTH-1:0]      tw_real,
    input  logic [WIDTH-1:0]      tw_imag,
    output logic                  wr_en,
    output logic [N_LOG2-1:0]     wr_addr_a,
    output logic [N_LOG2-1:0]     wr_addr_b,
    output logic [2*WIDTH-1:0]    wr_data_a,
    output logic [2*WIDTH-1:0]    wr_data_b
);

    localparam int                SW     = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
    localparam logic [N_LOG2-2:0] K_LAST = '1;

    fft_state_t          r_state, w_next_state;
    logic [SW-1:0]       r_s;
    logic [N_LOG2-2:0]   r_k;
    logic                r_drain;
    logic [N_LOG2-1:0]   w_addr_a, w_addr_b;
    logic [N_LOG2-2:0]   w_tw_addr;
    logic                r_vld_p1;
    logic [N_LOG2-1:0]   r_addr_a_p1, r_addr_b_p1;
    logic [2*WIDTH-1:0]  w_out1, w_out2;

    fft_addr_gen #(.N_LOG2(N_LOG2), .SW(SW)) u_addr_gen (
        .i_s       (r_s),
        .i_k       (r_k),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    butterfly_mod #(.WIDTH(WIDTH)) u_bfly (
        .i_a    (rd_data_a),
        .i_b    (rd_data_b),
        .i_w_re (tw_real),
        .i_w_im (tw_imag),
        .o_x1   (w_out1),
        .o_x2   (w_out2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_k     <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_s     <= '0;
                        r_k     <= '0;
                        r_drain <= 1'b0;
                    end
                end
                ST_RUN:   r_k <= r_k + 1'b1;
                // Two idle cycles let the last butterfly of the stage land before the next reads.
                ST_DRAIN: begin
                    r_drain <= ~r_drain;
                    if (r_drain && (r_s != S_LAST))
                        r_s <= r_s + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        rd_en        = 1'b0;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_RUN;
            ST_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (r_k == K_LAST) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drain) w_next_state = (r_s == S_LAST) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_addr_a = '0;
        rd_addr_b = '0;
        tw_addr   = '0;
        if (rd_en) begin
            rd_addr_a = w_addr_a;
            rd_addr_b = w_addr_b;
            tw_addr   = w_tw_addr;
        end
    end

    // p1: RAM/ROM data in flight; p2: butterfly result registered onto the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1    <= 1'b0;
            r_addr_a_p1 <= '0;
            r_addr_b_p1 <= '0;
            wr_en       <= 1'b0;
            wr_addr_a   <= '0;
            wr_addr_b   <= '0;
            wr_data_a   <= '0;
            wr_data_b   <= '0;
        end else begin
            r_vld_p1    <= rd_en;
            r_addr_a_p1 <= rd_addr_a;
            r_addr_b_p1 <= rd_addr_b;
            wr_en       <= r_vld_p1;
            wr_addr_a   <= r_addr_a_p1;
            wr_addr_b   <= r_addr_b_p1;
            wr_data_a   <= w_out1;
            wr_data_b   <= w_out2;
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl at N=8: address trace, timing, impulse/cosine spectra, reset abort.
module tb_fft_ctrl;
    import fft_pkg::*;

    localparam int NL = 3;
    localparam int N  = 8;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, rd_en, wr_en;
    logic [NL-1:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [NL-2:0]   tw_addr;
    logic [2*W-1:0]  rd_data_a = '0, rd_data_b = '0;
    logic [W-1:0]    tw_real = '0, tw_imag = '0;
    logic [2*W-1:0]  wr_data_a, wr_data_b;

    fft_ctrl #(.N_LOG2(NL), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .tw_addr(tw_addr), .tw_real(tw_real), .tw_imag(tw_imag),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .wr_data_a(wr_data_a), .wr_data_b(wr_data_b)
    );

    always #5 clk = ~clk;

    // W_8^idx = cos(2*pi*idx/8) - i*sin(2*pi*idx/8), Q1.15
    logic [15:0] TW_RE [4] = '{16'h7FFF, 16'h5A82, 16'h0000, 16'hA57E};
    logic [15:0] TW_IM [4] = '{16'h0000, 16'hA57E, 16'h8000, 16'hA57E};

`ifdef FFT_CTRL_SCALE_EN
    logic [15:0] COS_X [8] = '{16'h2000, 16'h16A1, 16'h0000, 16'hE95F,
                               16'hE000, 16'hE95F, 16'h0000, 16'h16A1};
    localparam logic [15:0] IMP_OUT = 16'h0800;
`else
    logic [15:0] COS_X [8] = '{16'h0400, 16'h02D4, 16'h0000, 16'hFD2C,
                               16'hFC00, 16'hFD2C, 16'h0000, 16'h02D4};
    localparam logic [15:0] IMP_OUT = 16'h4000;
`endif
    localparam logic [15:0] COS_PEAK = 16'h1000;

    // Expected issue order for N=8: addr_a, addr_b, twiddle per butterfly
    int TA [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int TB [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int TT [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    typedef struct packed { logic [2:0] a; logic [2:0] b; logic [1:0] t; } tr_t;
    typedef struct packed { logic [15:0] re; logic [15:0] im; logic [7:0] tol; } bin_t;

    tr_t  q_rd [$];
    tr_t  q_wr [$];
    int   q_lat [$];
    int   q_busy [$];
    bin_t q_bin [$];

    logic [2*W-1:0] mem [N];
    logic           ld_en = 1'b0;
    logic [NL-1:0]  ld_addr = '0;
    logic [2*W-1:0] ld_data = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bcnt    = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_tol(input string name, input logic [15:0] act, input logic [15:0] exp,
                           input int tol);
        int d;
        d = int'($signed(act)) - int'($signed(exp));
        n_tests++;
        if (d > tol || d < -tol) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (+/-%0d)", name, act, exp, tol);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_en) mem[ld_addr] <= ld_data;
        if (wr_en) begin
            mem[wr_addr_a] <= wr_data_a;
            mem[wr_addr_b] <= wr_data_b;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
            tw_real   <= TW_RE[tw_addr];
            tw_imag   <= TW_IM[tw_addr];
        end
    end

    // Issue monitor
    always @(negedge clk) begin
        if (rst_n && rd_en) begin
            if (q_rd.size() == 0) chk("rd_extra", 64'(rd_en), 64'd0);
            else chk("rd_addr", 64'({rd_addr_a, rd_addr_b, tw_addr}), 64'(q_rd.pop_front()));
            q_lat.push_back(cyc);
        end
    end

    // Write monitor
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (q_wr.size() == 0) chk("wr_extra", 64'(wr_en), 64'd0);
            else chk("wr_addr", 64'({wr_addr_a, wr_addr_b, 2'b00}),
                     64'({q_wr[0].a, q_wr[0].b, 2'b00}));
            if (q_wr.size() != 0) void'(q_wr.pop_front());
            if (q_lat.size() != 0) chk("wr_latency", 64'(cyc - q_lat.pop_front()), 64'd2);
        end
    end

    // Completion monitor: busy length, done pulse, final spectrum in RAM
    always @(negedge clk) begin
        if (!rst_n) begin
            bcnt      = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) bcnt++;
            if (prev_done) chk("done_width", 64'(done), 64'd0);
            if (done) begin
                chk("done_busy_low", 64'(busy), 64'd0);
                if (q_busy.size() == 0) chk("done_extra", 64'(done), 64'd0);
                else chk("busy_cycles", 64'(bcnt), 64'(q_busy.pop_front()));
                bcnt = 0;
                for (int i = 0; i < N; i++) begin
                    if (q_bin.size() != 0) begin
                        bin_t e;
                        e = q_bin.pop_front();
                        chk_tol($sformatf("bin%0d_re", i), mem[i][31:16], e.re, int'(e.tol));
                        chk_tol($sformatf("bin%0d_im", i), mem[i][15:0],  e.im, int'(e.tol));
                    end
                end
            end
            prev_done = done;
        end
    end

    function automatic logic [2:0] br3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    task automatic load(input bit cosine);
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = br3(3'(n));
            if (cosine) ld_data = {COS_X[n], 16'h0000};
            else        ld_data = (n == 0) ? 32'h4000_0000 : 32'h0;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_expect(input bit cosine);
        q_busy.push_back(NL * (N / 2 + 2));
        for (int i = 0; i < 12; i++) begin
            q_rd.push_back(tr_t'{3'(TA[i]), 3'(TB[i]), 2'(TT[i])});
            q_wr.push_back(tr_t'{3'(TA[i]), 3'(TB[i]), 2'(TT[i])});
        end
        for (int i = 0; i < N; i++) begin
            if (cosine) q_bin.push_back(bin_t'{(i == 1 || i == 7) ? COS_PEAK : 16'h0, 16'h0, 8'd8});
            else        q_bin.push_back(bin_t'{IMP_OUT, 16'h0, 8'd0});
        end
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 64'(got), 64'd1);
        @(negedge clk);
    endtask

    task automatic run_fft(input bit cosine, input bit poke);
        load(cosine);
        push_expect(cosine);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            repeat (5) @(negedge clk);
            start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #2;
        chk("rst_ctrl", 64'({busy, done, rd_en, wr_en}), 64'd0);
        chk("rst_addr", 64'({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 64'd0);
        chk("rst_wdata", 64'({wr_data_a, wr_data_b}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_fft(1'b0, 1'b0);
        run_fft(1'b1, 1'b0);

        load(1'b1);
        push_expect(1'b1);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ctrl", 64'({busy, done, rd_en, wr_en}), 64'd0);
        chk("abort_addr", 64'({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 64'd0);
        chk("abort_wdata", 64'({wr_data_a, wr_data_b}), 64'd0);
        q_rd.delete(); q_wr.delete(); q_lat.delete(); q_busy.delete(); q_bin.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_wr", 64'({wr_en, rd_en}), 64'd0);
        end
        rst_n = 1'b1;

        run_fft(1'b1, 1'b0);
        run_fft(1'b0, 1'b1);

        repeat (4) @(negedge clk);
        chk("q_rd_drained", 64'(q_rd.size()), 64'd0);
        chk("q_wr_drained", 64'(q_wr.size()), 64'd0);
        chk("q_busy_drained", 64'(q_busy.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
